// File: rtl/cnn_maxpool2x2_pkg.sv
// cnn_maxpool2x2_pkg: pooling window size and row-phase states for the 2x2 max-pool stage.
package cnn_maxpool2x2_pkg;
  localparam int POOL_K = 2;
  typedef enum logic {ROW_EVEN = 1'b0, ROW_ODD = 1'b1} row_state_t;
endpackage

// File: rtl/cnn_maxpool2x2_row_buffer.sv
// pool_row_buffer: one even-row's worth of horizontal pair maxima, sync write / async read.
module pool_row_buffer #(
  parameter int W  = 16,
  parameter int D  = 2,
  parameter int AW = D > 1 ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/cnn_maxpool2x2.sv
// cnn_maxpool2x2: 2x2 stride-2 unsigned max-pool over a raster CO-channel fmap stream.
module cnn_maxpool2x2
  import cnn_maxpool2x2_pkg::*;
#(
  parameter int CO    = 2,
  parameter int DW    = 8,
  parameter int IMG_W = 4,
  parameter int IMG_H = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  input  logic [CO*DW-1:0] i_in_fmap,
  output logic             o_ot_valid,
  output logic [CO*DW-1:0] o_ot_fmap,
  output logic             o_frame_done
);
  localparam int BD = IMG_W / POOL_K;
  localparam int AW = BD > 1 ? $clog2(BD) : 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  row_state_t state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CO*DW-1:0] hold, pair_max, quad_max, rbuf;
  logic last_col, last_row, take, buf_we;
  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a > b ? a : b;
  endfunction
  assign last_col = col == CW'(IMG_W - 1);
  assign last_row = row == RW'(IMG_H - 1);
  assign take     = i_in_valid && !i_clear;
  assign buf_we   = take && col[0] && state == ROW_EVEN;
  for (genvar c = 0; c < CO; c++) begin : g_max
    assign pair_max[c*DW +: DW] = max2(hold[c*DW +: DW], i_in_fmap[c*DW +: DW]);
    assign quad_max[c*DW +: DW] = max2(pair_max[c*DW +: DW], rbuf[c*DW +: DW]);
  end
  pool_row_buffer #(.W(CO*DW), .D(BD), .AW(AW)) u_row_buffer (
    .clk   (clk),
    .we    (buf_we),
    .addr  (AW'(col >> 1)),
    .wdata (pair_max),
    .rdata (rbuf)
  );
  // the last row of an odd-height frame is even-phase, so the frame wrap always lands in ROW_EVEN
  always_comb begin
    state_nxt = state;
    if (i_clear) state_nxt = ROW_EVEN;
    else if (i_in_valid && last_col)
      state_nxt = (state == ROW_EVEN && !last_row) ? ROW_ODD : ROW_EVEN;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ROW_EVEN;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      hold         <= '0;
      o_ot_valid   <= 1'b0;
      o_ot_fmap    <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_clear) begin
        col <= '0;
        row <= '0;
      end else if (i_in_valid) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col) begin
          row          <= last_row ? '0 : row + 1'b1;
          o_frame_done <= last_row;
        end
        if (!col[0]) hold <= i_in_fmap;
        else if (state == ROW_ODD) begin
          o_ot_fmap  <= quad_max;
          o_ot_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_cnn_maxpool2x2.sv
// tb_cnn_maxpool2x2: directed + random frames on a 4x4 and a 5x5 instance against a window-max model.
module tb_cnn_maxpool2x2;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0;
  logic v4 = 1'b0, v5 = 1'b0;
  logic [15:0] f4 = '0, f5 = '0;
  logic ov4, ov5, dn4, dn5;
  logic [15:0] of4, of5;
  int total = 0, bad = 0;
  logic [15:0] px [2][25];
  logic [15:0] fr [25];
  logic [15:0] exp_f [2];
  int idx [2];
  logic [15:0] got [$];
  int done_cnt;
  always #5 clk = ~clk;
  cnn_maxpool2x2 #(.CO(2), .DW(8), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .reset_n(reset_n), .i_clear(clear), .i_in_valid(v4), .i_in_fmap(f4),
    .o_ot_valid(ov4), .o_ot_fmap(of4), .o_frame_done(dn4));
  cnn_maxpool2x2 #(.CO(2), .DW(8), .IMG_W(5), .IMG_H(5)) u5 (
    .clk(clk), .reset_n(reset_n), .i_clear(clear), .i_in_valid(v5), .i_in_fmap(f5),
    .o_ot_valid(ov5), .o_ot_fmap(of5), .o_frame_done(dn5));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic check_all(input logic ev0, input logic ed0, input logic ev1, input logic ed1);
    chk("valid4", 32'(ov4), 32'(ev0));
    chk("done4", 32'(dn4), 32'(ed0));
    chk("fmap4", 32'(of4), 32'(exp_f[0]));
    chk("valid5", 32'(ov5), 32'(ev1));
    chk("done5", 32'(dn5), 32'(ed1));
    chk("fmap5", 32'(of5), 32'(exp_f[1]));
  endtask
  // one clock: drive, let the edge happen, then update the model and compare both instances
  task automatic step(input int d, input logic v, input logic [15:0] data, input logic clr);
    logic ev [2];
    logic ed [2];
    int w, r, c;
    logic [7:0] m, p;
    ev = '{1'b0, 1'b0};
    ed = '{1'b0, 1'b0};
    v4 = (d == 0) && v;
    v5 = (d == 1) && v;
    f4 = data;
    f5 = data;
    clear = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      idx[0] = 0;
      idx[1] = 0;
    end else if (v) begin
      w = d ? 5 : 4;
      px[d][idx[d]] = data;
      r = idx[d] / w;
      c = idx[d] % w;
      if (r % 2 == 1 && c % 2 == 1) begin
        for (int ch = 0; ch < 2; ch++) begin
          m = 8'd0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              p = px[d][(r - dr) * w + c - dc][ch*8 +: 8];
              if (p > m) m = p;
            end
          exp_f[d][ch*8 +: 8] = m;
        end
        ev[d] = 1'b1;
      end
      if (idx[d] == w * w - 1) begin
        ed[d] = 1'b1;
        idx[d] = 0;
      end else idx[d]++;
    end
    check_all(ev[0], ed[0], ev[1], ed[1]);
    if (d == 0 && ov4) got.push_back(of4);
    if (d == 1 && ov5) got.push_back(of5);
    if (dn4 || dn5) done_cnt++;
  endtask
  task automatic send(input int d, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      step(d, 1'b1, fr[i], 1'b0);
      repeat ($urandom_range(maxgap, 0)) step(d, 1'b0, 16'($urandom), 1'b0);
    end
  endtask
  task automatic load_pattern4();
    for (int i = 0; i < 16; i++) fr[i] = {8'(15 - i), 8'(i)};
  endtask
  task automatic load_random();
    for (int i = 0; i < 25; i++) fr[i] = 16'($urandom);
  endtask
  task automatic check_s1(input string tag);
    logic [15:0] want [4];
    want = '{16'h0F05, 16'h0D07, 16'h070D, 16'h050F};
    chk({tag, "_count"}, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(want[i]));
  endtask
  initial begin
    exp_f = '{16'h0, 16'h0};
    idx = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    check_all(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(0, 1'b0, 16'h0, 1'b0);
    // scenario 1: ramp frame
    load_pattern4();
    got.delete();
    send(0, 16, 0);
    check_s1("s1");
    // scenario 2: same frame with idle gaps
    got.delete();
    send(0, 16, 3);
    check_s1("s2");
    // scenario 3: two back-to-back random frames, then the ramp
    done_cnt = 0;
    load_random();
    send(0, 16, 0);
    load_random();
    send(0, 16, 0);
    chk("s3_done_count", 32'(done_cnt), 32'd2);
    got.delete();
    load_pattern4();
    send(0, 16, 0);
    check_s1("s3_after");
    // scenario 4: 5x5 ramp, then a random 5x5 frame to prove the wrap
    for (int i = 0; i < 25; i++) fr[i] = {8'd0, 8'(i)};
    got.delete();
    done_cnt = 0;
    send(1, 25, 1);
    chk("s4_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("s4", 32'(got[i]), 32'((i / 2) * 10 + (i % 2) * 2 + 6));
    chk("s4_done", 32'(done_cnt), 32'd1);
    load_random();
    send(1, 25, 2);
    // scenario 5: clear after 6 pixels, clear cycle also carries a pixel
    load_random();
    send(0, 6, 0);
    step(0, 1'b1, 16'hFFFF, 1'b1);
    got.delete();
    load_pattern4();
    send(0, 16, 0);
    check_s1("s5");
    // scenario 6: async reset mid-frame
    load_random();
    send(0, 7, 0);
    reset_n = 1'b0;
    #1;
    exp_f = '{16'h0, 16'h0};
    idx = '{0, 0};
    check_all(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    got.delete();
    load_pattern4();
    send(0, 16, 0);
    check_s1("s6");
    // scenario 7: 0xFF against 0x00 in the first window
    load_random();
    fr[0] = 16'h00FF;
    fr[1] = 16'h0000;
    fr[4] = 16'h0000;
    fr[5] = 16'hFF00;
    got.delete();
    send(0, 16, 0);
    chk("s7_count", 32'(got.size()), 32'd4);
    if (got.size() > 0) chk("s7", 32'(got[0]), 32'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
